// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract unit: one CHUNK-bit slice per stage, the carry
// registered between stages, valid/ready handshake with a whole-pipeline stall.
module pipe_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int unsigned CHUNK = WIDTH / STAGES;

    logic [WIDTH-1:0] yy;
    logic             adv;

    assign yy       = sub ? ~y : y;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = k * CHUNK;

        logic [CHUNK-1:0]    cur_x;
        logic [CHUNK-1:0]    cur_y;
        logic                cur_c;
        logic                cur_v;
        logic [CHUNK:0]      add;
        logic [LO+CHUNK-1:0] s_new;
        logic [LO+CHUNK-1:0] s_q;
        logic                v_q;

        if (k == 0) begin : g_src
            assign cur_x = x[CHUNK-1:0];
            assign cur_y = yy[CHUNK-1:0];
            assign cur_c = sub;
            assign cur_v = in_valid;
            assign s_new = add[CHUNK-1:0];
        end else begin : g_src
            // The previous stage's remainder starts with this stage's chunk.
            assign cur_x = g_stage[k-1].g_rem.x_q[CHUNK-1:0];
            assign cur_y = g_stage[k-1].g_rem.y_q[CHUNK-1:0];
            assign cur_c = g_stage[k-1].g_rem.c_q;
            assign cur_v = g_stage[k-1].v_q;
            assign s_new = {add[CHUNK-1:0], g_stage[k-1].s_q};
        end

        assign add = {1'b0, cur_x} + {1'b0, cur_y} + {{CHUNK{1'b0}}, cur_c};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
                v_q <= 1'b0;
            end else if (adv) begin
                s_q <= s_new;
                v_q <= cur_v;
            end
        end

        if (k < STAGES - 1) begin : g_rem
            localparam int unsigned REM = WIDTH - LO - CHUNK;

            logic [REM-1:0] x_d;
            logic [REM-1:0] y_d;
            logic [REM-1:0] x_q;
            logic [REM-1:0] y_q;
            logic           c_q;

            if (k == 0) begin : g_rsrc
                assign x_d = x[WIDTH-1:CHUNK];
                assign y_d = yy[WIDTH-1:CHUNK];
            end else begin : g_rsrc
                assign x_d = g_stage[k-1].g_rem.x_q[REM+CHUNK-1:CHUNK];
                assign y_d = g_stage[k-1].g_rem.y_q[REM+CHUNK-1:CHUNK];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    x_q <= '0;
                    y_q <= '0;
                    c_q <= 1'b0;
                end else if (adv) begin
                    x_q <= x_d;
                    y_q <= y_d;
                    c_q <= add[CHUNK];
                end
            end
        end else begin : g_flags
            logic cout_q;
            logic ovf_q;
            logic zero_q;

            // The top chunk's MSBs are the operand sign bits.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    cout_q <= add[CHUNK];
                    ovf_q  <= (cur_x[CHUNK-1] == cur_y[CHUNK-1]) &&
                              (s_new[WIDTH-1] != cur_x[CHUNK-1]);
                    zero_q <= ~|s_new;
                end
            end
        end
    end

    assign sum       = g_stage[STAGES-1].s_q;
    assign out_valid = g_stage[STAGES-1].v_q;
    assign cout      = g_stage[STAGES-1].g_flags.cout_q;
    assign ovf       = g_stage[STAGES-1].g_flags.ovf_q;
    assign zero      = g_stage[STAGES-1].g_flags.zero_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder: instances with STAGES = 4, 1 and 8 share the
// stimulus; each retire is checked against a per-instance scoreboard.
module tb_pipe_adder;
    localparam int unsigned W = 32;
    localparam int NDUT = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         sub;
    logic         out_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         ir [NDUT];
    logic         ov [NDUT];
    logic         co [NDUT];
    logic         of [NDUT];
    logic         zr [NDUT];
    logic [W-1:0] sm [NDUT];

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [34:0] sb [NDUT][64];
    int          stamp [NDUT][64];
    int          wr [NDUT];
    int          rd [NDUT];
    int          ret_cnt [NDUT];
    logic        acc [NDUT];
    logic        hold_prev [NDUT];
    logic [34:0] out_prev [NDUT];
    logic        lat_chk;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(W), .STAGES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .x(x), .y(y),
        .sub(sub), .out_valid(ov[0]), .out_ready(out_ready), .sum(sm[0]), .cout(co[0]),
        .ovf(of[0]), .zero(zr[0])
    );
    pipe_adder #(.WIDTH(W), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .x(x), .y(y),
        .sub(sub), .out_valid(ov[1]), .out_ready(out_ready), .sum(sm[1]), .cout(co[1]),
        .ovf(of[1]), .zero(zr[1])
    );
    pipe_adder #(.WIDTH(W), .STAGES(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .x(x), .y(y),
        .sub(sub), .out_valid(ov[2]), .out_ready(out_ready), .sum(sm[2]), .cout(co[2]),
        .ovf(of[2]), .zero(zr[2])
    );

    function automatic int stg(input int d);
        if (d == 0) return 4;
        if (d == 1) return 1;
        return 8;
    endfunction

    // Returns {ovf, zero, cout, sum}.
    function automatic logic [34:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
        longint       sa;
        longint       sb2;
        longint       res;
        logic [W-1:0] r;
        logic         c;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        if (s) begin
            res = sa - sb2;
            r   = a - b;
            c   = (a >= b);
        end else begin
            res = sa + sb2;
            r   = a + b;
            c   = (({1'b0, a} + {1'b0, b}) > 33'h0_FFFF_FFFF);
        end
        return {(res != longint'($signed(r))), (r == '0), c, r};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sb();
        for (int d = 0; d < NDUT; d++) begin
            wr[d] = 0;
            rd[d] = 0;
            ret_cnt[d] = 0;
            hold_prev[d] = 1'b0;
            out_prev[d] = '0;
            acc[d] = 1'b0;
        end
    endtask

    // One cycle: drive at negedge, then account for the coming posedge.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic r, input logic [34:0] e);
        @(negedge clk);
        in_valid = v;
        x = a;
        y = b;
        sub = s;
        out_ready = r;
        #1;
        cyc++;
        for (int d = 0; d < NDUT; d++) begin
            if (hold_prev[d])
                check($sformatf("hold%0d", d), {28'b0, ov[d], of[d], zr[d], co[d], sm[d]},
                      {28'b0, 1'b1, out_prev[d]});
            check($sformatf("ready%0d", d), {63'b0, ir[d]}, {63'b0, (!ov[d] || r)});
            if (ov[d] && r) begin
                if (rd[d] == wr[d]) begin
                    check($sformatf("spurious%0d", d), 64'(wr[d] - rd[d]), 64'd1);
                end else begin
                    check($sformatf("result%0d", d), {29'b0, of[d], zr[d], co[d], sm[d]},
                          {29'b0, sb[d][rd[d] % 64]});
                    if (lat_chk)
                        check($sformatf("latency%0d", d), 64'(cyc - stamp[d][rd[d] % 64]),
                              64'(stg(d)));
                    rd[d]++;
                    ret_cnt[d]++;
                end
            end
            acc[d] = v && ir[d];
            if (acc[d]) begin
                sb[d][wr[d] % 64] = e;
                stamp[d][wr[d] % 64] = cyc;
                wr[d]++;
            end
            hold_prev[d] = ov[d] && !r;
            out_prev[d] = {of[d], zr[d], co[d], sm[d]};
        end
    endtask

    task automatic drain_check(input string tag);
        repeat (12) step(1'b0, '0, '0, 1'b0, 1'b1, '0);
        for (int d = 0; d < NDUT; d++)
            check($sformatf("%s%0d", tag, d), 64'(wr[d] - rd[d]), 64'd0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [34:0] e);
        lat_chk = 1'b1;
        step(1'b1, a, b, s, 1'b1, e);
        drain_check("drain");
        lat_chk = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int sent;
        int n;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic s;

        in_valid = 1'b0;
        x = '0;
        y = '0;
        sub = 1'b0;
        out_ready = 1'b0;
        lat_chk = 1'b0;
        rst_n = 1'b1;
        clear_sb();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < NDUT; d++)
            check($sformatf("reset%0d", d), {28'b0, ov[d], of[d], zr[d], co[d], sm[d]}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++)
            check($sformatf("rst_ready%0d", d), {63'b0, ir[d]}, 64'd1);

        // {ovf, zero, cout, sum}
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {1'b0, 1'b1, 1'b1, 32'h0000_0000});
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, {1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF});
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE});
        run_op(32'h00FF_FFFF, 32'h0000_0001, 1'b0, {1'b0, 1'b0, 1'b0, 32'h0100_0000});
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {1'b1, 1'b0, 1'b0, 32'h8000_0000});
        run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, {1'b0, 1'b0, 1'b0, 32'h2222_2221});
        run_op(32'h0000_0007, 32'h0000_0007, 1'b1, {1'b0, 1'b1, 1'b1, 32'h0000_0000});
        run_op(32'h0000_0000, 32'h0000_0001, 1'b1, {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF});
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, {1'b1, 1'b1, 1'b1, 32'h0000_0000});

        // Eight back-to-back ops with a three-cycle consumer stall mid-stream.
        clear_sb();
        sent = 0;
        for (int i = 0; i < 30; i++) begin
            a = 32'(sent) * 32'h1357_9BDF + 32'hF0F0_0000;
            b = ~a ^ (32'(sent) << 3);
            s = sent[0];
            step(sent < 8, a, b, s, !(i >= 6 && i < 9), ref_op(a, b, s));
            if (i >= 6 && i < 9)
                check("stall_ready", {63'b0, ir[0]}, 64'd0);
            if (acc[0]) sent++;
        end
        check("stream_count", 64'(ret_cnt[0]), 64'd8);
        drain_check("stream_drain");

        // Asynchronous reset with three ops in flight and the head result held.
        clear_sb();
        for (int i = 0; i < 3; i++) begin
            a = 32'hA5A5_0000 + 32'(i);
            b = 32'h0101_0101 * 32'(i + 1);
            step(1'b1, a, b, 1'b0, 1'b0, ref_op(a, b, 1'b0));
        end
        n = 0;
        while (!ov[0] && n < 10) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, '0);
            n++;
        end
        check("fill", {63'b0, ov[0]}, 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++)
            check($sformatf("rst_async%0d", d), {28'b0, ov[d], of[d], zr[d], co[d], sm[d]},
                  64'd0);
        clear_sb();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", {63'b0, ir[0]}, 64'd1);
        repeat (10) step(1'b0, '0, '0, 1'b0, 1'b1, '0);
        check("no_stale", 64'(ret_cnt[0] + ret_cnt[1] + ret_cnt[2]), 64'd0);
        run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, {1'b0, 1'b0, 1'b0, 32'h0001_0000});

        // Random traffic with random in_valid/out_ready on all three depths.
        clear_sb();
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = ~a;
                1: b = a;
                default: ;
            endcase
            s = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 99) < 70), a, b, s, 1'($urandom_range(0, 99) < 70),
                 ref_op(a, b, s));
        end
        drain_check("rand_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
